// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: pipelined logic-function unit with N/Z/err flags, valid/ready on both sides and a completed-op counter
module logic_unit_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o,
  output logic             flag_n,
  output logic             flag_z,
  output logic             err,
  output logic [CNT_W-1:0] op_count
);
  typedef struct packed {
    logic [WIDTH-1:0] o;
    logic             n;
    logic             z;
    logic             e;
  } res_t;
  logic [WIDTH-1:0] w_r;
  res_t             w_din [STAGES+1];
  logic [STAGES:0]  w_vin;
  logic [STAGES-1:0] w_rdy;
  logic [CNT_W-1:0] r_cnt;
  always_comb begin
    case (op)
      4'd0:    w_r = a & b;
      4'd1:    w_r = a | b;
      4'd2:    w_r = a ^ b;
      4'd3:    w_r = ~(a & b);
      4'd4:    w_r = ~(a | b);
      4'd5:    w_r = a & ~b;
      4'd6:    w_r = a | ~b;
      4'd7:    w_r = ~(a ^ b);
      4'd8:    w_r = ~b;
      4'd9:    w_r = b;
      default: w_r = '0;
    endcase
  end
  assign w_din[0] = {w_r, w_r[WIDTH-1], ~|w_r, op > 4'd9};
  assign w_vin[0] = in_valid;
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    res_t r_d;
    logic r_v;
    // A stage can load if out_ready drains the tail or any stage from here onward is empty
    assign w_rdy[k] = out_ready | ~&w_vin[STAGES:k+1];
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        r_v <= 1'b0;
        r_d <= '0;
      end else if (w_rdy[k]) begin
        r_v <= w_vin[k];
        if (w_vin[k]) r_d <= w_din[k];
      end
    assign w_vin[k+1] = r_v;
    assign w_din[k+1] = r_d;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else if (out_valid && out_ready) r_cnt <= r_cnt + 1'b1;
  assign in_ready  = w_rdy[0];
  assign out_valid = w_vin[STAGES];
  assign o         = w_din[STAGES].o;
  assign flag_n    = w_din[STAGES].n;
  assign flag_z    = w_din[STAGES].z;
  assign err       = w_din[STAGES].e;
  assign op_count  = r_cnt;
endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: scoreboard bench for logic_unit_pipe (STAGES=2), plus a CNT_W=4 twin for counter wrap
module tb_logic_unit_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] a = '0, b = '0;
  logic [3:0]  op = '0;
  logic        in_ready, out_valid, flag_n, flag_z, err;
  logic [31:0] o;
  logic [15:0] op_count;
  logic        in_ready4, out_valid4, flag_n4, flag_z4, err4;
  logic [31:0] o4;
  logic [3:0]  op_count4;
  typedef struct packed {
    logic [31:0] o;
    logic        n;
    logic        z;
    logic        e;
  } exp_t;
  exp_t q[$];
  exp_t e_pop;
  int   errors = 0, checks = 0, n_xfer = 0;

  logic_unit_pipe #(.WIDTH(32), .STAGES(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready), .o(o), .flag_n(flag_n), .flag_z(flag_z),
    .err(err), .op_count(op_count));
  logic_unit_pipe #(.WIDTH(32), .STAGES(2), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .a(a), .b(b), .op(op),
    .out_valid(out_valid4), .out_ready(out_ready), .o(o4), .flag_n(flag_n4), .flag_z(flag_z4),
    .err(err4), .op_count(op_count4));

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic [3:0] c);
    exp_t r;
    case (c)
      4'd0: r.o = x & y;
      4'd1: r.o = x | y;
      4'd2: r.o = x ^ y;
      4'd3: r.o = ~(x & y);
      4'd4: r.o = ~(x | y);
      4'd5: r.o = x & ~y;
      4'd6: r.o = x | ~y;
      4'd7: r.o = ~(x ^ y);
      4'd8: r.o = ~y;
      4'd9: r.o = y;
      default: r.o = 32'h0;
    endcase
    r.n = r.o[31];
    r.z = (r.o == 32'h0);
    r.e = (c >= 4'd10);
    return r;
  endfunction

  always @(negedge clk)
    if (!rst && out_valid && out_ready) begin
      n_xfer++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL sb_extra: unexpected result o=%h", o);
      end else begin
        e_pop = q.pop_front();
        if ({o, flag_n, flag_z, err} !== e_pop) begin
          errors++;
          $display("FAIL sb_data: got o=%h n=%b z=%b e=%b, want o=%h n=%b z=%b e=%b",
                   o, flag_n, flag_z, err, e_pop.o, e_pop.n, e_pop.z, e_pop.e);
        end
      end
    end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [3:0] c);
    a = x; b = y; op = c; in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(model(x, y, c));
        @(posedge clk);
        #1 in_valid = 1'b0;
        a = $urandom; b = $urandom; op = 4'($urandom);
        return;
      end
    end
    errors++; checks++;
    $display("FAIL send_timeout: in_ready=%b, want 1 within 200 cycles", in_ready);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0;
    q.delete();
    n_xfer = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({out_valid, o, flag_n, flag_z, err, op_count} !== '0) begin
      errors++;
      $display("FAIL reset_state: ov=%b o=%h n=%b z=%b e=%b cnt=%0d, want all 0",
               out_valid, o, flag_n, flag_z, err, op_count);
    end
    do_reset();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_bic_latency();
    out_ready = 1'b1;
    send(32'hFFFF00FF, 32'h0F0F0F0F, 4'b0101);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL lat_early: out_valid=%b, want 0 after accept edge", out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if ({out_valid, o, flag_n, flag_z, err} !== {1'b1, 32'hF0F000F0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL bic_out: ov=%b o=%h n=%b z=%b e=%b, want 1 F0F000F0 1 0 0",
               out_valid, o, flag_n, flag_z, err);
    end
    @(posedge clk); #1;
    checks++;
    if (op_count !== 16'd1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bic_count: op_count=%0d out_valid=%b, want 1/0", op_count, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] start;
    int run, w;
    start = op_count; run = 0; w = 0;
    fork
      for (int c = 0; c < 10; c++) send(32'h12345678, 32'h0000FFFF, 4'(c));
      begin
        while (!out_valid && w < 50) begin @(negedge clk); w++; end
        while (out_valid && run < 20) begin run++; @(negedge clk); end
      end
    join
    checks++;
    if (run !== 10) begin
      errors++;
      $display("FAIL b2b_run: consecutive out_valid cycles=%0d, want 10", run);
    end
    repeat (3) @(posedge clk); #1;
    checks++;
    if (op_count !== start + 16'd10 || q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count: op_count=%0d pending=%0d, want %0d/0", op_count, q.size(), start + 16'd10);
    end
  endtask

  task automatic test_illegal();
    logic [15:0] start;
    int w;
    start = op_count; w = 0;
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1100);
    while (!out_valid && w < 50) begin @(negedge clk); w++; end
    checks++;
    if ({out_valid, o, flag_n, flag_z, err} !== {1'b1, 32'h0, 1'b0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL illegal_out: ov=%b o=%h n=%b z=%b e=%b, want 1 0 0 1 1",
               out_valid, o, flag_n, flag_z, err);
    end
    @(posedge clk); #1;
    checks++;
    if (op_count !== start + 16'd1) begin
      errors++;
      $display("FAIL illegal_count: op_count=%0d, want %0d", op_count, start + 16'd1);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] start;
    logic [31:0] held, ra [4], rb [4];
    logic [3:0]  ops [4];
    start = op_count;
    ops[0] = 4'd0; ops[1] = 4'd6; ops[2] = 4'd2; ops[3] = 4'd8;
    for (int i = 0; i < 4; i++) begin ra[i] = $urandom; rb[i] = $urandom; end
    out_ready = 1'b0;
    fork
      for (int i = 0; i < 4; i++) send(ra[i], rb[i], ops[i]);
      begin
        repeat (6) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || q.size() != 2) begin
          errors++;
          $display("FAIL bp_full: in_ready=%b out_valid=%b accepted=%0d, want 0/1/2",
                   in_ready, out_valid, q.size());
        end
        held = o;
        repeat (3) @(negedge clk);
        checks++;
        if (o !== held || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL bp_hold: o=%h out_valid=%b, want %h/1", o, out_valid, held);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk); #1;
    checks++;
    if (q.size() != 0 || op_count !== start + 16'd4) begin
      errors++;
      $display("FAIL bp_drain: pending=%0d op_count=%0d, want 0/%0d", q.size(), op_count, start + 16'd4);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    out_ready = 1'b0;
    send(32'hA5A5A5A5, 32'h0F0F0F0F, 4'd1);
    send(32'h00000000, 32'h00000000, 4'd4);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || op_count !== 16'd0) begin
      errors++;
      $display("FAIL rst_async: out_valid=%b op_count=%0d, want 0/0", out_valid, op_count);
    end
    q.delete();
    n_xfer = 0;
    @(posedge clk);
    #3 rst = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready: in_ready=%b, want 1", in_ready);
    end
    repeat (6) begin @(negedge clk); if (out_valid) seen++; end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rst_stale: stale out_valid cycles=%0d, want 0", seen);
    end
  endtask

  task automatic test_count_wrap();
    int w;
    w = 0;
    do_reset();
    out_ready = 1'b1;
    fork
      for (int i = 0; i < 17; i++) send($urandom, $urandom, 4'($urandom_range(0, 15)));
      begin
        while (n_xfer < 16 && w < 200) begin @(posedge clk); #1; w++; end
        checks++;
        if (n_xfer != 16 || op_count4 !== 4'd0) begin
          errors++;
          $display("FAIL wrap16: transfers=%0d op_count=%0d, want 16/0", n_xfer, op_count4);
        end
        while (n_xfer < 17 && w < 200) begin @(posedge clk); #1; w++; end
        checks++;
        if (n_xfer != 17 || op_count4 !== 4'd1 || op_count !== 16'd17) begin
          errors++;
          $display("FAIL wrap17: transfers=%0d op_count4=%0d op_count=%0d, want 17/1/17",
                   n_xfer, op_count4, op_count);
        end
      end
    join
  endtask

  initial begin
    test_reset();
    test_bic_latency();
    test_back_to_back();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    test_count_wrap();
    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
